// File: rtl/sprite_pixel_ctrl_if.sv
// Sprite pixel controller bus.
// Groups the pixel stream, the position-update port, the sprite ROM port and
// the palette-index output of sprite_pixel_ctrl.
//   master : VGA timing / CPU / ROM side (drives pixels, updates, rom_data)
//   slave  : sprite_pixel_ctrl (drives ROM request, colour index, status)
interface sprite_pixel_ctrl_if #(
    parameter int ROM_AW = 12
);
    logic [9:0]        pix_x;
    logic [9:0]        pix_y;
    logic              pix_valid;
    logic              frame_start;
    logic [9:0]        pos_x_in;
    logic [9:0]        pos_y_in;
    logic              flip_in;
    logic              pos_wr;
    logic              pos_pending;
    logic              rom_en;
    logic [ROM_AW-1:0] rom_addr;
    logic [2:0]        rom_data;
    logic [2:0]        color_idx;
    logic              color_valid;
    logic              hit;

    modport master (
        output pix_x, pix_y, pix_valid, frame_start,
        output pos_x_in, pos_y_in, flip_in, pos_wr,
        output rom_data,
        input  pos_pending, rom_en, rom_addr, color_idx, color_valid, hit
    );

    modport slave (
        input  pix_x, pix_y, pix_valid, frame_start,
        input  pos_x_in, pos_y_in, flip_in, pos_wr,
        input  rom_data,
        output pos_pending, rom_en, rom_addr, color_idx, color_valid, hit
    );
endinterface

// File: rtl/sprite_pixel_ctrl.sv
// Sprite pixel controller: window test, ROM addressing, transparency and a
// two-cycle aligned palette index for one animated, movable sprite. Also holds
// the double-buffered position/flip registers and the animation counter.
//   clk   : pixel clock
//   rst_n : asynchronous active-low reset
//   bus   : sprite_pixel_ctrl_if.slave (pixel in, position update, ROM port,
//           color_idx/color_valid/hit out, pos_pending status)
//
// Update FSM
//   state   | meaning
//   IDLE    | shadow registers match committed position, nothing to commit
//   PENDING | shadow holds an update waiting for the next frame_start
module sprite_pixel_ctrl #(
    parameter int SPR_W       = 32,
    parameter int SPR_H       = 32,
    parameter int ANIM_FRAMES = 4,
    parameter int ANIM_DIV    = 8,
    parameter int ROM_AW      = 12
) (
    input  logic                clk,
    input  logic                rst_n,
    sprite_pixel_ctrl_if.slave  bus
);
    localparam int XW  = (SPR_W > 1) ? $clog2(SPR_W) : 1;
    localparam int YW  = (SPR_H > 1) ? $clog2(SPR_H) : 1;
    localparam int AFW = (ANIM_FRAMES > 1) ? $clog2(ANIM_FRAMES) : 1;
    localparam int DVW = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;

    typedef enum logic {IDLE, PENDING} state_t;

    state_t            state_q, state_d;
    logic              commit;
    logic [9:0]        sh_x_q, sh_y_q, pos_x_q, pos_y_q;
    logic              sh_flip_q, flip_q;
    logic [AFW-1:0]    anim_q;
    logic [DVW-1:0]    div_q;

    logic signed [10:0] dx, dy;
    logic              in_win;
    logic [XW-1:0]     col;
    logic [ROM_AW-1:0] addr_d;

    logic              rom_en_q, vld1_q, win2_q, vld2_q;
    logic [ROM_AW-1:0] rom_addr_q;
    logic              opaque;

    // ---------------- update FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // A write in the same cycle as a commit keeps us PENDING: the old shadow
    // commits while the new value lands in the shadow.
    always_comb begin
        state_d = state_q;
        commit  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.pos_wr) state_d = PENDING;
            end
            PENDING: begin
                if (bus.frame_start) begin
                    commit = 1'b1;
                    if (!bus.pos_wr) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_x_q    <= '0;
            sh_y_q    <= '0;
            sh_flip_q <= 1'b0;
            pos_x_q   <= '0;
            pos_y_q   <= '0;
            flip_q    <= 1'b0;
        end else begin
            if (bus.pos_wr) begin
                sh_x_q    <= bus.pos_x_in;
                sh_y_q    <= bus.pos_y_in;
                sh_flip_q <= bus.flip_in;
            end
            if (commit) begin
                pos_x_q <= sh_x_q;
                pos_y_q <= sh_y_q;
                flip_q  <= sh_flip_q;
            end
        end
    end

    // ---------------- animation counter ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q  <= '0;
            anim_q <= '0;
        end else if (bus.frame_start) begin
            if (div_q == DVW'(ANIM_DIV - 1)) begin
                div_q  <= '0;
                anim_q <= (anim_q == AFW'(ANIM_FRAMES - 1)) ? '0 : anim_q + AFW'(1);
            end else begin
                div_q <= div_q + DVW'(1);
            end
        end
    end

    // ---------------- stage 0: window test and address ----------------
    // Zero-extended 11-bit differences: negative means left of / above the
    // sprite, so a sprite hanging off the right edge never wraps to column 0.
    assign dx = $signed({1'b0, bus.pix_x}) - $signed({1'b0, pos_x_q});
    assign dy = $signed({1'b0, bus.pix_y}) - $signed({1'b0, pos_y_q});

    assign in_win = bus.pix_valid
                 && !dx[10] && ({1'b0, dx[9:0]} < 11'(SPR_W))
                 && !dy[10] && ({1'b0, dy[9:0]} < 11'(SPR_H));

    assign col = flip_q ? (XW'(SPR_W - 1) - dx[XW-1:0]) : dx[XW-1:0];

    assign addr_d = ROM_AW'(anim_q) * ROM_AW'(SPR_W * SPR_H)
                  + ROM_AW'(dy[YW-1:0]) * ROM_AW'(SPR_W)
                  + ROM_AW'(col);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rom_en_q   <= 1'b0;
            rom_addr_q <= '0;
            vld1_q     <= 1'b0;
            win2_q     <= 1'b0;
            vld2_q     <= 1'b0;
        end else begin
            rom_en_q   <= in_win;
            rom_addr_q <= in_win ? addr_d : '0;
            vld1_q     <= bus.pix_valid;
            win2_q     <= rom_en_q;
            vld2_q     <= vld1_q;
        end
    end

    // ---------------- stage 2: transparency ----------------
    // rom_data arrives in the same cycle as win2_q; output is combinational
    // from it so total latency stays at two cycles. Indices 0 and 7 are clear.
    assign opaque = win2_q && (bus.rom_data != 3'd0) && (bus.rom_data != 3'd7);

    assign bus.rom_en      = rom_en_q;
    assign bus.rom_addr    = rom_addr_q;
    assign bus.color_idx   = opaque ? bus.rom_data : 3'd0;
    assign bus.hit         = opaque;
    assign bus.color_valid = vld2_q;
    assign bus.pos_pending = (state_q == PENDING);
endmodule

// File: tb/tb_sprite_pixel_ctrl.sv
module tb_sprite_pixel_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sprite_pixel_ctrl_if #(.ROM_AW(12)) bus ();

    sprite_pixel_ctrl #(
        .SPR_W(32), .SPR_H(32), .ANIM_FRAMES(4), .ANIM_DIV(8), .ROM_AW(12)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Registered sprite ROM
    logic [2:0] rom_mem [4096];
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)          bus.rom_data <= 3'd0;
        else if (bus.rom_en) bus.rom_data <= rom_mem[bus.rom_addr];
    end

    int n_pass = 0;
    int n_checks = 0;

    // Reference model state
    int c_x, c_y, c_flip, s_x, s_y, s_flip, pend, fs_count;
    int e1_w, e1_a, e1_v, e2_w, e2_a, e2_v;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic model_reset();
        c_x = 0; c_y = 0; c_flip = 0; s_x = 0; s_y = 0; s_flip = 0;
        pend = 0; fs_count = 0;
        e1_w = 0; e1_a = 0; e1_v = 0; e2_w = 0; e2_a = 0; e2_v = 0;
    endtask

    task automatic pix(input int x, input int y, input bit v);
        bus.pix_x = 10'(x);
        bus.pix_y = 10'(y);
        bus.pix_valid = v;
    endtask

    task automatic wr(input int x, input int y, input bit f);
        bus.pos_x_in = 10'(x);
        bus.pos_y_in = 10'(y);
        bus.flip_in = f;
        bus.pos_wr = 1'b1;
    endtask

    // One clock: predict from the sprite rules, advance, compare every output.
    task automatic step();
        int dx, dy, col, w, a, v, anim, r, op;
        anim = (fs_count / 8) % 4;
        v  = int'(bus.pix_valid);
        dx = int'(bus.pix_x) - c_x;
        dy = int'(bus.pix_y) - c_y;
        w  = (v != 0 && dx >= 0 && dx < 32 && dy >= 0 && dy < 32) ? 1 : 0;
        col = (c_flip != 0) ? 31 - dx : dx;
        a  = (w != 0) ? anim * 1024 + dy * 32 + col : 0;
        if (bus.frame_start) begin
            if (pend != 0) begin
                c_x = s_x; c_y = s_y; c_flip = s_flip;
            end
            fs_count++;
        end
        if (bus.pos_wr) begin
            s_x = int'(bus.pos_x_in); s_y = int'(bus.pos_y_in); s_flip = int'(bus.flip_in);
            pend = 1;
        end else if (bus.frame_start) begin
            pend = 0;
        end
        @(posedge clk);
        #1;
        bus.pos_wr = 1'b0;
        bus.frame_start = 1'b0;
        e2_w = e1_w; e2_a = e1_a; e2_v = e1_v;
        e1_w = w;    e1_a = a;    e1_v = v;
        r  = int'(rom_mem[e2_a]);
        op = (e2_w != 0 && r != 0 && r != 7) ? 1 : 0;
        chk("rom_en", 32'(bus.rom_en), 32'(e1_w));
        chk("rom_addr", 32'(bus.rom_addr), 32'(e1_a));
        chk("color_valid", 32'(bus.color_valid), 32'(e2_v));
        chk("color_idx", 32'(bus.color_idx), (op != 0) ? 32'(r) : 32'd0);
        chk("hit", 32'(bus.hit), 32'(op));
        chk("pos_pending", 32'(bus.pos_pending), 32'(pend));
    endtask

    task automatic fs_step();
        bus.frame_start = 1'b1;
        step();
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) rom_mem[i] = 3'($urandom_range(0, 7));
        rom_mem[0]    = 3'd3;
        rom_mem[63]   = 3'd7;
        rom_mem[339]  = 3'd5;
        rom_mem[1024] = 3'd2;
        model_reset();
        pix(0, 0, 1'b0);
        bus.frame_start = 1'b0;
        bus.pos_wr = 1'b0;
        bus.pos_x_in = '0;
        bus.pos_y_in = '0;
        bus.flip_in = 1'b0;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rom_en", 32'(bus.rom_en), 0);
        chk("rst_rom_addr", 32'(bus.rom_addr), 0);
        chk("rst_color_idx", 32'(bus.color_idx), 0);
        chk("rst_color_valid", 32'(bus.color_valid), 0);
        chk("rst_hit", 32'(bus.hit), 0);
        chk("rst_pending", 32'(bus.pos_pending), 0);
        rst_n = 1'b1;

        // Update held in shadow; committed position still (0,0)
        wr(100, 50, 1'b0); step();
        chk("plan_pending", 32'(bus.pos_pending), 1);
        pix(100, 50, 1'b1); step();
        chk("plan_uncommitted_en", 32'(bus.rom_en), 0);
        pix(0, 0, 1'b0); step();
        chk("plan_uncommitted_hit", 32'(bus.hit), 0);

        // Commit, then hit at the sprite origin
        fs_step();
        chk("plan_committed", 32'(bus.pos_pending), 0);
        pix(100, 50, 1'b1); step();
        chk("plan_origin_en", 32'(bus.rom_en), 1);
        chk("plan_origin_addr", 32'(bus.rom_addr), 0);
        pix(132, 50, 1'b1); step();
        chk("plan_origin_color", 32'(bus.color_idx), 3);
        chk("plan_origin_hit", 32'(bus.hit), 1);
        chk("plan_origin_valid", 32'(bus.color_valid), 1);
        chk("plan_right_edge_en", 32'(bus.rom_en), 0);
        pix(0, 0, 1'b0); step();
        chk("plan_right_edge_color", 32'(bus.color_idx), 0);
        step();

        // Horizontal flip and transparent index 7
        wr(100, 50, 1'b1); step();
        fs_step();
        pix(100, 51, 1'b1); step();
        chk("plan_flip_addr", 32'(bus.rom_addr), 63);
        pix(0, 0, 1'b0); step();
        chk("plan_transp_color", 32'(bus.color_idx), 0);
        chk("plan_transp_hit", 32'(bus.hit), 0);

        // Clipping at the right screen edge, no wrap to column 0
        wr(620, 50, 1'b0); step();
        fs_step();
        pix(639, 60, 1'b1); step();
        chk("plan_clip_en", 32'(bus.rom_en), 1);
        chk("plan_clip_addr", 32'(bus.rom_addr), 339);
        pix(0, 60, 1'b1); step();
        chk("plan_nowrap_en", 32'(bus.rom_en), 0);
        chk("plan_clip_hit", 32'(bus.hit), 1);
        chk("plan_clip_color", 32'(bus.color_idx), 5);

        // Reset mid-line flushes immediately and drops a pending update
        pix(639, 60, 1'b1); step(); step();
        wr(10, 10, 1'b1); step();
        rst_n = 1'b0;
        #1;
        chk("midrst_rom_en", 32'(bus.rom_en), 0);
        chk("midrst_color_idx", 32'(bus.color_idx), 0);
        chk("midrst_color_valid", 32'(bus.color_valid), 0);
        chk("midrst_hit", 32'(bus.hit), 0);
        chk("midrst_pending", 32'(bus.pos_pending), 0);
        model_reset();
        pix(0, 0, 1'b0);
        #2 rst_n = 1'b1;

        // Animation: 8 frame_start pulses per step, 4 frames
        wr(100, 50, 1'b0); step();
        repeat (8) fs_step();
        pix(100, 50, 1'b1); step();
        chk("plan_anim1_addr", 32'(bus.rom_addr), 1024);
        pix(0, 0, 1'b0); step();
        repeat (24) fs_step();
        pix(100, 50, 1'b1); step();
        chk("plan_anim_wrap_addr", 32'(bus.rom_addr), 0);
        pix(0, 0, 1'b0); step(); step();

        // Write coinciding with frame_start: old shadow commits, new one waits
        wr(200, 100, 1'b0); step();
        wr(300, 150, 1'b0); bus.frame_start = 1'b1; step();
        chk("plan_ab_pending", 32'(bus.pos_pending), 1);
        pix(200, 100, 1'b1); step();
        chk("plan_a_committed", 32'(bus.rom_en), 1);
        pix(0, 0, 1'b0); fs_step();
        chk("plan_b_commit_pending", 32'(bus.pos_pending), 0);
        pix(300, 150, 1'b1); step();
        chk("plan_b_committed", 32'(bus.rom_en), 1);
        pix(200, 100, 1'b1); step();
        chk("plan_a_replaced", 32'(bus.rom_en), 0);

        // Randomized traffic against the model
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 7) == 0)
                pix(int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)),
                    1'($urandom_range(0, 1)));
            else
                pix(c_x - 4 + int'($urandom_range(0, 40)), c_y - 4 + int'($urandom_range(0, 40)),
                    ($urandom_range(0, 3) != 0));
            if ($urandom_range(0, 39) == 0)
                wr(int'($urandom_range(0, 639)), int'($urandom_range(0, 479)),
                   1'($urandom_range(0, 1)));
            if ($urandom_range(0, 29) == 0) bus.frame_start = 1'b1;
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/sprite_pixel_ctrl.md
Name: sprite_pixel_ctrl

Overview:
- Sequences the sprite ROM and the 3-bit palette index path for one movable, animated character sprite.
- Takes the current pixel coordinate from the VGA timing generator and decides whether the pixel lies inside the sprite window.
- Issues the sprite ROM read, applies transparency, and delivers an aligned 3-bit colour index to the palette decoder.
- Also owns the double-buffered sprite position/flip registers, committed at frame boundaries, and the animation-frame counter.

Parameters:
- SPR_W, 32, sprite width in pixels; power of two.
- SPR_H, 32, sprite height in pixels; power of two.
- ANIM_FRAMES, 4, number of animation frames stored back-to-back in ROM; power of two.
- ANIM_DIV, 8, video frames per animation step; must be ≥1.
- ROM_AW, 12, ROM address width; equals log2(SPR_W*SPR_H*ANIM_FRAMES).

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  asynchronous active-low reset
- pix_x  in  10  current pixel column
- pix_y  in  10  current pixel row
- pix_valid  in  1  pix_x/pix_y are inside the active area this cycle
- frame_start  in  1  one-cycle pulse at the start of vertical blanking
- pos_x_in  in  10  new sprite left edge
- pos_y_in  in  10  new sprite top edge
- flip_in  in  1  new horizontal-mirror flag
- pos_wr  in  1  write strobe for pos_x_in/pos_y_in/flip_in
- pos_pending  out  1  shadow holds an uncommitted update
- rom_en  out  1  ROM read enable
- rom_addr  out  ROM_AW  ROM read address
- rom_data  in  3  ROM palette index; registered ROM, valid 1 cycle after rom_en
- color_idx  out  3  palette index to decoder; 0 = background
- color_valid  out  1  color_idx corresponds to an active pixel
- hit  out  1  opaque sprite pixel on color_idx

Behaviour:
- Clock and reset: single clock clk; rst_n asynchronous, active-low.
- Reset values:
  - All outputs 0.
  - Committed pos_x/pos_y = 0, flip = 0.
  - Shadow registers = 0.
  - anim_idx = 0, div_cnt = 0.
  - Update FSM = IDLE.
- Update FSM, states IDLE / PENDING:
  - IDLE: pos_wr loads the shadow registers and moves to PENDING.
  - PENDING: pos_wr overwrites the shadow (last write wins). On frame_start, the shadow content held before that cycle is copied to the committed registers and the FSM returns to IDLE.
  - pos_wr and frame_start in the same cycle: the old shadow commits; the new value loads the shadow; the FSM stays PENDING.
  - frame_start while IDLE: no commit.
  - pos_pending = (state == PENDING).
- Animation counter: on each frame_start, div_cnt increments.
  - When div_cnt == ANIM_DIV-1, div_cnt clears and anim_idx increments modulo ANIM_FRAMES (wraps ANIM_FRAMES-1 → 0).
  - The anim_idx used for ROM addressing changes only at frame_start, never mid-frame.
- Stage 0 (cycle N, pixel accepted):
  - dx = pix_x - pos_x and dy = pix_y - pos_y, computed in 11-bit signed arithmetic.
  - in_win = pix_valid && 0 ≤ dx < SPR_W && 0 ≤ dy < SPR_H.
  - Sprites partly past the right or bottom edge clip naturally; there is no wrap-around to the left or top.
  - col = flip ? SPR_W-1-dx : dx.
  - rom_addr = anim_idx*SPR_W*SPR_H + dy*SPR_W + col; rom_en = in_win.
  - These outputs are registered: rom_addr/rom_en appear at cycle N+1.
- ROM stage: rom_data is valid at cycle N+2.
- Stage 2 output (cycle N+2):
  - color_valid = pix_valid delayed by 2 cycles.
  - If in_win is delayed true and rom_data ∉ {0, 7}, then color_idx = rom_data and hit = 1.
  - Otherwise color_idx = 0 and hit = 0. Index 7 is treated as transparent, same as 0.
- Total latency from pix_x/pix_y to color_idx is exactly 2 cycles. The timing generator delays hsync/vsync by 2 cycles to match.
- When pix_valid = 0: rom_en = 0, and color_valid/hit/color_idx are 0 two cycles later.
- Commit during the active area never occurs, because frame_start is only asserted in blanking. The pipeline always uses the committed registers.
- Reset mid-line: the pipeline flushes to 0 immediately, and the pending update is lost.

Test Plan:
- Reset, then pos_wr with x=100, y=50, flip=0, no frame_start → pos_pending=1; pixel (100,50) gives hit=0 and color_idx=0, since the committed position is still (0,0).
- After frame_start: pixel (100,50) with ROM[0]=3 → rom_en=1 and rom_addr=0 at +1 cycle; color_idx=3, hit=1, color_valid=1 at +2 cycles. Pixel (132,50) → rom_en=0, color_idx=0.
- flip=1, pixel (100,51) → rom_addr=63 (row 1, col 31). Transparency: ROM returning 7 → color_idx=0, hit=0.
- pos_x=620: pixel (639,y) → hit allowed at dx=19; pixel (0,y) → in_win=0, no wrap.
- ANIM_DIV=8: after 8 frame_start pulses, anim_idx=1 and pixel (pos_x,pos_y) gives rom_addr=1024. After 32 pulses anim_idx wraps to 0.
- pos_wr A, then pos_wr B and frame_start in the same cycle → A committed, B pending. The next frame_start commits B. Asserting rst_n=0 mid-line → all outputs 0 the same cycle.
